// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined add/subtract unit:
// mode encodings and stage-count helper.
package adder_pipe_pkg;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   function automatic int nstg(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// CHUNK-bit combinational ripple-carry adder slice.
// One instance resolves one pipeline stage of adder_pipe.
module adder_slice
   import adder_pipe_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic c;

   always_comb begin
      s = '0;
      c = cin;
      for (int i = 0; i < CHUNK; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one CHUNK slice per stage, carry
// registered between stages, valid/ready with a global advance.
module adder_pipe
   import adder_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTG = nstg(WIDTH, CHUNK);
   localparam int L    = NSTG - 1;

   logic             adv;
   logic             vr [NSTG];
   logic             cr [NSTG];
   logic [WIDTH-1:0] ar [NSTG];
   logic [WIDTH-1:0] br [NSTG];
   logic [WIDTH-1:0] sr [NSTG];

   logic             vi [NSTG];
   logic             ci [NSTG];
   logic             co [NSTG];
   logic [WIDTH-1:0] ai [NSTG];
   logic [WIDTH-1:0] bi [NSTG];
   logic [WIDTH-1:0] pi [NSTG];
   logic [WIDTH-1:0] sn [NSTG];

   assign adv      = !vr[L] || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam logic [WIDTH-1:0] MASK =
         WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

      logic [CHUNK-1:0] ps;

      if (k == 0) begin : g_in
         assign vi[k] = in_valid;
         assign ai[k] = a;
         assign bi[k] = (sub == SUB) ? ~b : b;
         assign ci[k] = (sub == SUB) ? 1'b1 : cin;
         assign pi[k] = '0;
      end else begin : g_mid
         assign vi[k] = vr[k-1];
         assign ai[k] = ar[k-1];
         assign bi[k] = br[k-1];
         assign ci[k] = cr[k-1];
         assign pi[k] = sr[k-1];
      end

      adder_slice #(
         .CHUNK(CHUNK)
      ) u_slice (
         .a   (ai[k][k*CHUNK +: CHUNK]),
         .b   (bi[k][k*CHUNK +: CHUNK]),
         .cin (ci[k]),
         .s   (ps),
         .cout(co[k])
      );

      // merge this slice into the lower sums already resolved
      assign sn[k] = (pi[k] & ~MASK)
                   | ((WIDTH'(ps) << (k * CHUNK)) & MASK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSTG; i++) begin
            vr[i] <= 1'b0;
            cr[i] <= 1'b0;
            ar[i] <= '0;
            br[i] <= '0;
            sr[i] <= '0;
         end
      end else if (adv) begin
         for (int i = 0; i < NSTG; i++) begin
            vr[i] <= vi[i];
            cr[i] <= co[i];
            ar[i] <= ai[i];
            br[i] <= bi[i];
            sr[i] <= sn[i];
         end
      end
   end

   assign out_valid = vr[L];
   assign s         = sr[L];
   assign cout      = cr[L];
   assign ovf       = (ar[L][WIDTH-1] == br[L][WIDTH-1])
                   && (sr[L][WIDTH-1] != ar[L][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: 4-stage and 1-stage
// instances, scoreboard queue plus directed boundary checks.
module tb_adder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, cin, sub;
   logic        out_valid, out_ready, cout, ovf;
   logic [31:0] a, b, s;

   logic        in_valid1, in_ready1, cin1, sub1;
   logic        out_valid1, out_ready1, cout1, ovf1;
   logic [15:0] a1, b1, s1;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
   } exp_t;

   exp_t q[$];
   exp_t q1[$];

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   logic        stall0, stall1;
   logic [31:0] hold0;
   logic [15:0] hold1;

   adder_pipe #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf)
   );

   adder_pipe #(.WIDTH(16), .CHUNK(16)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .sub(sub1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .s(s1), .cout(cout1), .ovf(ovf1)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] x,
                                  input logic [31:0] y,
                                  input logic ci,
                                  input logic sb,
                                  input int w);
      logic [32:0] m, bp, sum;
      exp_t e;
      m   = (33'd1 << w) - 33'd1;
      bp  = sb ? (~{1'b0, y}) & m : {1'b0, y} & m;
      sum = ({1'b0, x} & m) + bp + {32'd0, (sb ? 1'b1 : ci)};
      e.s = sum[31:0] & m[31:0];
      e.c = sum[w];
      e.o = (x[w-1] == bp[w-1]) && (sum[w-1] != x[w-1]);
      return e;
   endfunction

   task automatic tick(output bit acc);
      exp_t e;
      bit   acc1;
      @(negedge clk);
      acc  = in_valid && in_ready && !rst;
      acc1 = in_valid1 && in_ready1 && !rst;
      if (stall0) begin
         check("hold_valid", out_valid, 1);
         check("hold_s", s, hold0);
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) check("spurious_out", out_valid, 0);
         else begin
            e = q.pop_front();
            check("s", s, e.s);
            check("cout", cout, e.c);
            check("ovf", ovf, e.o);
         end
      end
      stall0 = out_valid && !out_ready;
      hold0  = s;
      if (acc) q.push_back(model(a, b, cin, sub, 32));
      if (stall1) check("hold_s1", s1, hold1);
      if (out_valid1 && out_ready1) begin
         if (q1.size() == 0) check("spurious_out1", out_valid1, 0);
         else begin
            e = q1.pop_front();
            check("s1", s1, e.s);
            check("cout1", cout1, e.c);
            check("ovf1", ovf1, e.o);
         end
      end
      stall1 = out_valid1 && !out_ready1;
      hold1  = s1;
      if (acc1) q1.push_back(model({16'd0, a1}, {16'd0, b1}, cin1, sub1, 16));
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         q1.delete();
         stall0 = 1'b0;
         stall1 = 1'b0;
      end
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic sb);
      bit acc;
      a = x; b = y; cin = ci; sub = sb;
      in_valid = 1'b1;
      tick(acc);
      check("accept", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      bit acc;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick(acc);
         lat++;
      end
   endtask

   task automatic drain();
      bit acc;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 30; i++)
         if (q.size() > 0) tick(acc);
      check("drain_empty", q.size(), 0);
   endtask

   initial begin
      bit acc;
      int lat, n, guard;
      rst = 1'b1;
      in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
      in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; out_ready1 = 1;
      stall0 = 0; stall1 = 0; hold0 = 0; hold1 = 0;
      tick(acc);
      tick(acc);
      rst = 1'b0;

      check("rst_out_valid", out_valid, 0);
      check("rst_s", s, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid1", out_valid1, 0);

      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      wait_out(lat);
      check("t1_latency", lat, 4);
      check("t1_s", s, 32'h0);
      check("t1_cout", cout, 1);
      check("t1_ovf", ovf, 0);
      tick(acc);

      send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
      wait_out(lat);
      check("t2a_s", s, 32'h7FFF_FFFF);
      check("t2a_cout", cout, 1);
      check("t2a_ovf", ovf, 1);
      tick(acc);

      send(32'd5, 32'd7, 1'b1, 1'b1);
      wait_out(lat);
      check("t2b_s", s, 32'hFFFF_FFFE);
      check("t2b_cout", cout, 0);
      check("t2b_ovf", ovf, 0);
      tick(acc);

      a1 = 16'h7FFF; b1 = 16'h0001; cin1 = 1; sub1 = 0;
      in_valid1 = 1'b1;
      tick(acc);
      in_valid1 = 1'b0;
      lat = 1;
      while (!out_valid1 && lat < 20) begin
         tick(acc);
         lat++;
      end
      check("t6_latency", lat, 1);
      check("t6_s", s1, 32'h8001);
      check("t6_ovf", ovf1, 1);
      check("t6_cout", cout1, 0);
      tick(acc);
      check("t6_empty", q1.size(), 0);

      n = 0;
      guard = 0;
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      while (n < 100 && guard < 2000) begin
         out_ready = 1'($urandom_range(0, 1));
         tick(acc);
         guard++;
         if (acc) begin
            n++;
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
         end
      end
      in_valid = 1'b0;
      check("t3_beats", n, 100);
      drain();

      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      check("t4_full_valid", out_valid, 1);
      check("t4_in_ready", in_ready, 0);
      a = 32'h1234_5678; b = 32'h1; cin = 0; sub = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(acc);
         check("t4_blocked", acc, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t4_drain_valid", out_valid, 1);
         tick(acc);
      end
      check("t4_empty", q.size(), 0);
      check("t4_idle", out_valid, 0);

      for (int i = 0; i < 3; i++)
         send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
      rst = 1'b1;
      tick(acc);
      rst = 1'b0;
      check("t5_out_valid", out_valid, 0);
      check("t5_s", s, 0);
      for (int i = 0; i < 6; i++) tick(acc);
      check("t5_no_stale", out_valid, 0);
      send(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
      wait_out(lat);
      check("t5_latency", lat, 4);
      check("t5_s_new", s, 32'h0);
      tick(acc);
      check("t5_empty", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
